// File: rtl/trsq8_pkg.sv
// Shared definitions for TRSQ8 peripherals: interrupt controller register
// offsets, FSM state encoding and the IVEC packing helper.
package trsq8_pkg;

  // Register offsets relative to the controller's base address
  localparam logic [7:0] IRQ_IEN   = 8'd0;
  localparam logic [7:0] IRQ_IPEND = 8'd1;
  localparam logic [7:0] IRQ_IVEC  = 8'd2;
  localparam logic [7:0] IRQ_ICFG  = 8'd3;

  // Number of registers in the controller's address window
  localparam logic [7:0] IRQ_NUM_REGS = 8'd4;

  // Interrupt pulse FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } irq_state_t;

  // IVEC layout: {valid, 4'b0, idx[2:0]}
  function automatic logic [7:0] irq_ivec_pack(input logic valid, input logic [2:0] idx);
    irq_ivec_pack = {valid, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Single interrupt source front end: optional synchroniser chain followed by
// a previous-value flop; emits a one-cycle strobe on each rising edge.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_ip,
  input  logic reset_ip,
  input  logic src_ip,
  output logic event_op
);

  logic cur_w;
  logic prev_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // Source is already synchronous to clk_ip
      assign cur_w = src_ip;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw source through the synchroniser chain
      always_ff @(posedge clk_ip or posedge reset_ip) begin
        if (reset_ip) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src_ip;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign cur_w = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the last synchronised level for edge detection
  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= cur_w;
    end
  end

  // Cleared flops at reset mean a source held high produces one event
  assign event_op = cur_w & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// TRSQ8 interrupt controller: edge-captures up to eight sources into IPEND,
// masks them with IEN, prioritises (index 0 highest) and drives the CPU
// interrupt line with a fixed-length pulse. Four bus registers: IEN, IPEND
// (write-1-to-clear), IVEC (read acknowledges) and ICFG (global enable).
module irq_ctrl
  import trsq8_pkg::*;
#(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         SYNC_STAGES = 2,
  parameter int         PULSE_LEN   = 2
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  input  logic [N_SRC-1:0] src_ip,
  input  logic [7:0]       addr_ip,
  input  logic [7:0]       data_ip,
  input  logic             wr_en_ip,
  input  logic             rd_en_ip,
  output logic [7:0]       data_op,
  output logic             irq_op
);

  // Counter value loaded on PULSE entry; reaching zero ends the pulse
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);

  // Lowest-numbered set bit wins; 0 when nothing is requested
  function automatic logic [2:0] prio_enc(input logic [N_SRC-1:0] req);
    prio_enc = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        prio_enc = 3'(i);
      end
    end
  endfunction

  // Register state
  logic [N_SRC-1:0] ien_q, ien_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             gie_q, gie_d;
  irq_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  // Decode and datapath nets
  logic [7:0]       offset_w;
  logic             in_win_w;
  logic             sel_ien_w, sel_pend_w, sel_ivec_w, sel_icfg_w;
  logic [N_SRC-1:0] event_w;
  logic [N_SRC-1:0] active_w;
  logic             valid_w;
  logic [2:0]       idx_w;
  logic             ack_w;
  logic [N_SRC-1:0] ack_mask_w;
  logic [N_SRC-1:0] w1c_mask_w;

  // Per-source synchroniser and edge detector
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_edge (
        .clk_ip   (clk_ip),
        .reset_ip (reset_ip),
        .src_ip   (src_ip[gi]),
        .event_op (event_w[gi])
      );
    end
  endgenerate

  // Address window decode; the subtraction keeps the window check to one compare
  always_comb begin
    offset_w   = addr_ip - BASE_ADDR;
    in_win_w   = (offset_w < IRQ_NUM_REGS);
    sel_ien_w  = in_win_w && (offset_w == IRQ_IEN);
    sel_pend_w = in_win_w && (offset_w == IRQ_IPEND);
    sel_ivec_w = in_win_w && (offset_w == IRQ_IVEC);
    sel_icfg_w = in_win_w && (offset_w == IRQ_ICFG);
  end

  // Priority selection over enabled pending sources
  always_comb begin
    active_w = pend_q & ien_q;
    valid_w  = |active_w;
    idx_w    = prio_enc(active_w);
    ack_w    = rd_en_ip && sel_ivec_w && valid_w;
  end

  // Clear masks from a W1C write and from an IVEC acknowledge
  always_comb begin
    ack_mask_w = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_w && (idx_w == 3'(i))) begin
        ack_mask_w[i] = 1'b1;
      end
    end
    w1c_mask_w = (wr_en_ip && sel_pend_w) ? data_ip[N_SRC-1:0] : '0;
  end

  // Next register values; new events are ORed in last so a set beats any clear
  always_comb begin
    ien_d  = (wr_en_ip && sel_ien_w) ? data_ip[N_SRC-1:0] : ien_q;
    gie_d  = (wr_en_ip && sel_icfg_w) ? data_ip[0] : gie_q;
    pend_d = (pend_q & ~w1c_mask_w & ~ack_mask_w) | event_w;
  end

  // Configuration and pending registers
  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      ien_q  <= '0;
      pend_q <= '0;
      gie_q  <= 1'b0;
    end else begin
      ien_q  <= ien_d;
      pend_q <= pend_d;
      gie_q  <= gie_d;
    end
  end

  // FSM state register and pulse counter
  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: IDLE waits for work, PULSE times the pulse, WAIT holds
  // off until software acknowledges or the request goes away
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gie_q && valid_w) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT: begin
        if (ack_w || !valid_w || !gie_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM output: irq_op is a decode of the state register only
  always_comb begin
    irq_op = (state_q == PULSE);
  end

  // Combinational read mux; anything outside the window reads zero
  always_comb begin
    data_op = 8'h00;
    if (sel_ien_w) begin
      data_op = 8'(ien_q);
    end else if (sel_pend_w) begin
      data_op = 8'(pend_q);
    end else if (sel_ivec_w) begin
      data_op = irq_ivec_pack(valid_w, idx_w);
    end else if (sel_icfg_w) begin
      data_op = {7'b0000000, gie_q};
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: each stimulus step pushes its expected
// result, and the observed DUT value is popped against it when sampled.
module tb_irq_ctrl;

  localparam int         N_SRC       = 8;
  localparam logic [7:0] BASE        = 8'h10;
  localparam int         SYNC_STAGES = 2;
  localparam int         PULSE_LEN   = 2;

  logic             clk_ip = 1'b0;
  logic             reset_ip;
  logic [N_SRC-1:0] src_ip;
  logic [7:0]       addr_ip;
  logic [7:0]       data_ip;
  logic             wr_en_ip;
  logic             rd_en_ip;
  logic [7:0]       data_op;
  logic             irq_op;

  irq_ctrl #(
    .N_SRC       (N_SRC),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SYNC_STAGES),
    .PULSE_LEN   (PULSE_LEN)
  ) dut (
    .clk_ip   (clk_ip),
    .reset_ip (reset_ip),
    .src_ip   (src_ip),
    .addr_ip  (addr_ip),
    .data_ip  (data_ip),
    .wr_en_ip (wr_en_ip),
    .rd_en_ip (rd_en_ip),
    .data_op  (data_op),
    .irq_op   (irq_op)
  );

  always #5 clk_ip = ~clk_ip;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, obs, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ip);
    #1;
  endtask

  task automatic expect_addr(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    sb_push(tag, 32'(exp));
    addr_ip  = addr;
    rd_en_ip = 1'b0;
    @(negedge clk_ip);
    sb_pop(32'(data_op));
  endtask

  task automatic expect_reg(input string tag, input logic [7:0] off, input logic [7:0] exp);
    expect_addr(tag, BASE + off, exp);
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    sb_push(tag, 32'(exp));
    sb_pop(32'(irq_op));
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] data);
    addr_ip  = BASE + off;
    data_ip  = data;
    wr_en_ip = 1'b1;
    tick();
    wr_en_ip = 1'b0;
  endtask

  task automatic ack_read();
    addr_ip  = BASE + 8'd2;
    rd_en_ip = 1'b1;
    tick();
    rd_en_ip = 1'b0;
  endtask

  task automatic src_pulse(input logic [N_SRC-1:0] mask);
    src_ip = src_ip | mask;
    tick();
    src_ip = src_ip & ~mask;
  endtask

  // Edges from source rise to irq_op high; -1 if it never rises
  task automatic edge_to_irq(input logic [N_SRC-1:0] mask, output int n);
    n = -1;
    src_ip = src_ip | mask;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) src_ip = src_ip & ~mask;
      if (irq_op) begin
        n = i + 1;
        break;
      end
    end
  endtask

  // Called while irq_op is high: total high cycles
  task automatic count_high(output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!irq_op) break;
      n++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (irq_op) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset_ip = 1'b1;
    src_ip   = '0;
    addr_ip  = 8'h00;
    data_ip  = 8'h00;
    wr_en_ip = 1'b0;
    rd_en_ip = 1'b0;
    repeat (3) tick();
    expect_irq("rst_irq", 1'b0);
    @(negedge clk_ip);
    reset_ip = 1'b0;

    // Reset state
    expect_reg("rst_ien", 8'd0, 8'h00);
    expect_reg("rst_ipend", 8'd1, 8'h00);
    expect_reg("rst_ivec", 8'd2, 8'h00);
    expect_reg("rst_icfg", 8'd3, 8'h00);

    // Single source, latency and width
    bus_write(8'd0, 8'hFF);
    bus_write(8'd3, 8'hFF);
    expect_reg("icfg_rdmask", 8'd3, 8'h01);
    sb_push("t1_latency", 32'(SYNC_STAGES + 2));
    edge_to_irq(8'h08, n);
    sb_pop(32'(n));
    sb_push("t1_width", 32'(PULSE_LEN));
    count_high(n);
    sb_pop(32'(n));
    expect_reg("t1_ivec", 8'd2, 8'h83);
    expect_reg("t1_ipend", 8'd1, 8'h08);
    expect_addr("win_above", BASE + 8'd4, 8'h00);
    expect_addr("win_below", BASE - 8'd1, 8'h00);
    ack_read();
    expect_reg("t1_ack_ipend", 8'd1, 8'h00);
    expect_reg("t1_ack_ivec", 8'd2, 8'h00);
    sb_push("t1_quiet", 32'd0);
    count_pulses(6, n);
    sb_pop(32'(n));

    // Priority between two simultaneous sources
    sb_push("t2_latency", 32'(SYNC_STAGES + 2));
    edge_to_irq(8'h22, n);
    sb_pop(32'(n));
    sb_push("t2_width", 32'(PULSE_LEN));
    count_high(n);
    sb_pop(32'(n));
    expect_reg("t2_ivec1", 8'd2, 8'h81);
    ack_read();
    expect_irq("t2_idle_gap", 1'b0);
    tick();
    expect_irq("t2_second", 1'b1);
    sb_push("t2_width2", 32'(PULSE_LEN));
    count_high(n);
    sb_pop(32'(n));
    expect_reg("t2_ivec2", 8'd2, 8'h85);
    ack_read();
    expect_reg("t2_ipend", 8'd1, 8'h00);

    // Masked source is latched for polling only
    bus_write(8'd0, 8'h00);
    src_pulse(8'h04);
    sb_push("t3_masked_quiet", 32'd0);
    count_pulses(6, n);
    sb_pop(32'(n));
    expect_reg("t3_ipend", 8'd1, 8'h04);
    expect_reg("t3_ivec", 8'd2, 8'h00);
    bus_write(8'd0, 8'h04);
    expect_irq("t3_ien_edge0", 1'b0);
    tick();
    expect_irq("t3_ien_edge1", 1'b1);
    sb_push("t3_width", 32'(PULSE_LEN));
    count_high(n);
    sb_pop(32'(n));
    ack_read();
    expect_reg("t3_ipend_clr", 8'd1, 8'h00);

    // Collisions: set beats W1C and beats acknowledge
    bus_write(8'd0, 8'h00);
    bus_write(8'd3, 8'h00);
    src_pulse(8'h02);
    repeat (4) tick();
    expect_reg("t4_pre", 8'd1, 8'h02);
    src_pulse(8'h01);
    tick();
    bus_write(8'd1, 8'h03);
    expect_reg("t4_w1c_coll", 8'd1, 8'h01);
    bus_write(8'd0, 8'h01);
    expect_reg("t4_ivec", 8'd2, 8'h80);
    src_pulse(8'h01);
    tick();
    ack_read();
    expect_reg("t4_ack_coll", 8'd1, 8'h01);
    ack_read();
    expect_reg("t4_ack_plain", 8'd1, 8'h00);

    // Global enable gating, then reset in the middle of a pulse
    bus_write(8'd0, 8'hFF);
    src_pulse(8'h10);
    sb_push("t5_gie_quiet", 32'd0);
    count_pulses(8, n);
    sb_pop(32'(n));
    expect_reg("t5_ivec", 8'd2, 8'h84);
    bus_write(8'd3, 8'h01);
    expect_irq("t5_gie_edge0", 1'b0);
    tick();
    expect_irq("t5_gie_edge1", 1'b1);
    #2;
    reset_ip = 1'b1;
    #1;
    expect_irq("t5_async_drop", 1'b0);
    expect_reg("t5_rst_ien", 8'd0, 8'h00);
    expect_reg("t5_rst_ipend", 8'd1, 8'h00);
    expect_reg("t5_rst_ivec", 8'd2, 8'h00);
    expect_reg("t5_rst_icfg", 8'd3, 8'h00);
    reset_ip = 1'b0;
    sb_push("t5_post_quiet", 32'd0);
    count_pulses(5, n);
    sb_pop(32'(n));

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
